// File: rtl/button_responder.sv
// Push-button responder: synchronises and debounces the pad, tracks press/release with an FSM,
// and latches one press event until the core reads the button window.
module button_responder #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          PAD_ACTIVE_LOW  = 1'b1,
  parameter bit          LATCH_MODE      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_pad,
  input  logic btn_ren,
  output logic btn_out,
  output logic pressed
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
  // The IDLE/HELD cycle that first sees the new level counts as the first stable sample,
  // so the wait state covers the remaining DEBOUNCE_CYCLES-1 samples.
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 2);
  localparam logic [CntW-1:0] CntMax  = '1;
  localparam logic            PadReleased = PAD_ACTIVE_LOW;

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } state_e;

  logic            sync_meta;
  logic            sync_q;
  logic            p;
  logic            press_evt;
  logic            pending;
  logic [CntW-1:0] cnt;
  state_e          state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= PadReleased;
      sync_q    <= PadReleased;
    end else begin
      sync_meta <= btn_pad;
      sync_q    <= sync_meta;
    end
  end

  assign p         = sync_q ^ PAD_ACTIVE_LOW;
  assign press_evt = (state == StPressWait) && p && (cnt == CntLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      cnt     <= '0;
      pressed <= 1'b0;
      pending <= 1'b0;
    end else begin
      // A press in the same cycle as a read survives: set wins over clear.
      pending <= press_evt | (pending & ~btn_ren);
      unique case (state)
        StIdle: begin
          if (p) begin
            state <= StPressWait;
            cnt   <= '0;
          end
        end
        StPressWait: begin
          if (!p) begin
            state <= StIdle;
            cnt   <= '0;
          end else if (cnt == CntLast) begin
            state   <= StHeld;
            cnt     <= '0;
            pressed <= 1'b1;
          end else if (cnt != CntMax) begin
            cnt <= cnt + 1'b1;
          end
        end
        StHeld: begin
          if (!p) begin
            state <= StReleaseWait;
            cnt   <= '0;
          end
        end
        StReleaseWait: begin
          if (p) begin
            state <= StHeld;
            cnt   <= '0;
          end else if (cnt == CntLast) begin
            state   <= StIdle;
            cnt     <= '0;
            pressed <= 1'b0;
          end else if (cnt != CntMax) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= StIdle;
          cnt     <= '0;
          pressed <= 1'b0;
        end
      endcase
    end
  end

  assign btn_out = LATCH_MODE ? ~pending : ~pressed;

endmodule
